// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL manager terminating a crossbar port: Get/PutFull/PutPartial served from a flop word memory.
// Define TL_RESP_SKID_EN to replace the single D holding register with a 2-entry response FIFO.
module tl_ul_sram_responder #(
   parameter int unsigned DEPTH     = 256,
   parameter logic [27:0] ADDR_BASE = 28'h0800000,
   parameter int unsigned SOURCE_W  = 5
) (
   input  logic                clock,
   input  logic                reset,
   output logic                auto_in_a_ready,
   input  logic                auto_in_a_valid,
   input  logic [2:0]          auto_in_a_bits_opcode,
   input  logic [2:0]          auto_in_a_bits_param,
   input  logic [3:0]          auto_in_a_bits_size,
   input  logic [SOURCE_W-1:0] auto_in_a_bits_source,
   input  logic [27:0]         auto_in_a_bits_address,
   input  logic [3:0]          auto_in_a_bits_mask,
   input  logic [31:0]         auto_in_a_bits_data,
   input  logic                auto_in_a_bits_corrupt,
   input  logic                auto_in_d_ready,
   output logic                auto_in_d_valid,
   output logic [2:0]          auto_in_d_bits_opcode,
   output logic [1:0]          auto_in_d_bits_param,
   output logic [3:0]          auto_in_d_bits_size,
   output logic [SOURCE_W-1:0] auto_in_d_bits_source,
   output logic                auto_in_d_bits_sink,
   output logic                auto_in_d_bits_denied,
   output logic [31:0]         auto_in_d_bits_data,
   output logic                auto_in_d_bits_corrupt
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam logic [27:0] SPAN  = 28'(DEPTH * 4);

   typedef enum logic [2:0] {
      A_PUT_FULL    = 3'd0,
      A_PUT_PARTIAL = 3'd1,
      A_GET         = 3'd4
   } a_op_e;

   typedef enum logic [2:0] {
      D_ACCESS_ACK      = 3'd0,
      D_ACCESS_ACK_DATA = 3'd1
   } d_op_e;

   typedef struct packed {
      logic [2:0]          opcode;
      logic [3:0]          size;
      logic [SOURCE_W-1:0] source;
      logic                denied;
      logic [31:0]         data;
      logic                corrupt;
   } resp_t;

   logic [31:0]      mem [DEPTH];
   logic [27:0]      offset;
   logic [IDX_W-1:0] index;
   logic             misaligned;
   logic             req_err;
   logic             a_fire;
   logic             write_en;
   resp_t            new_resp;
   resp_t            head;
   logic             head_valid;
   logic             unused_param;

   assign unused_param = ^auto_in_a_bits_param;

   // Range check is a single unsigned compare on the rebased offset; addresses
   // below the base wrap to huge offsets but are also rejected explicitly.
   always_comb begin
      offset = auto_in_a_bits_address - ADDR_BASE;
      index  = offset[IDX_W+1:2];
      case (auto_in_a_bits_size)
         4'd0:    misaligned = 1'b0;
         4'd1:    misaligned = auto_in_a_bits_address[0];
         default: misaligned = |auto_in_a_bits_address[1:0];
      endcase
      req_err = (offset >= SPAN) || (auto_in_a_bits_address < ADDR_BASE) ||
                (auto_in_a_bits_size > 4'd2) || misaligned;

      new_resp        = '0;
      new_resp.size   = auto_in_a_bits_size;
      new_resp.source = auto_in_a_bits_source;
      write_en        = 1'b0;
      case (auto_in_a_bits_opcode)
         A_GET: begin
            new_resp.opcode  = D_ACCESS_ACK_DATA;
            new_resp.denied  = req_err;
            new_resp.corrupt = req_err;
            new_resp.data    = req_err ? '0 : mem[index];
         end
         A_PUT_FULL, A_PUT_PARTIAL: begin
            new_resp.opcode = D_ACCESS_ACK;
            new_resp.denied = req_err | auto_in_a_bits_corrupt;
            write_en        = a_fire & ~req_err & ~auto_in_a_bits_corrupt;
         end
         default: begin
            new_resp.opcode = D_ACCESS_ACK;
            new_resp.denied = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      for (int unsigned b = 0; b < 4; b++) begin
         if (write_en && auto_in_a_bits_mask[b]) begin
            mem[index][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
         end
      end
   end

`ifdef TL_RESP_SKID_EN
   resp_t      fifo [2];
   logic       rd_ptr;
   logic       wr_ptr;
   logic [1:0] count;
   logic [1:0] count_next;
   logic       a_ready_q;
   logic       d_fire;

   assign a_fire     = auto_in_a_valid & a_ready_q;
   assign d_fire     = head_valid & auto_in_d_ready;
   assign count_next = count + 2'(a_fire) - 2'(d_fire);

   // a_ready is precomputed from next occupancy so it never sees d_ready combinationally.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fifo[0]   <= '0;
         fifo[1]   <= '0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         count     <= '0;
         a_ready_q <= 1'b1;
      end else begin
         if (a_fire) begin
            fifo[wr_ptr] <= new_resp;
            wr_ptr       <= ~wr_ptr;
         end
         if (d_fire) begin
            rd_ptr <= ~rd_ptr;
         end
         count     <= count_next;
         a_ready_q <= (count_next < 2'd2);
      end
   end

   assign head            = fifo[rd_ptr];
   assign head_valid      = (count != 2'd0);
   assign auto_in_a_ready = a_ready_q;
`else
   resp_t hold;
   logic  hold_valid;

   assign auto_in_a_ready = ~hold_valid | auto_in_d_ready;
   assign a_fire          = auto_in_a_valid & auto_in_a_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold       <= '0;
         hold_valid <= 1'b0;
      end else if (a_fire) begin
         hold       <= new_resp;
         hold_valid <= 1'b1;
      end else if (auto_in_d_ready) begin
         hold_valid <= 1'b0;
      end
   end

   assign head       = hold;
   assign head_valid = hold_valid;
`endif

   assign auto_in_d_valid        = head_valid;
   assign auto_in_d_bits_opcode  = head.opcode;
   assign auto_in_d_bits_param   = '0;
   assign auto_in_d_bits_size    = head.size;
   assign auto_in_d_bits_source  = head.source;
   assign auto_in_d_bits_sink    = 1'b0;
   assign auto_in_d_bits_denied  = head.denied;
   assign auto_in_d_bits_data    = head.data;
   assign auto_in_d_bits_corrupt = head.corrupt;

endmodule

// File: doc/tl_ul_sram_responder.md
Name: tl_ul_sram_responder

Overview:
- TileLink-UL responder (manager end) that terminates a crossbar output port.
- Accepts single-beat A-channel requests: Get, PutFullData, PutPartialData.
- Serves them from an internal flop-based word memory and returns exactly one D-channel response per request.
- Address-range, size, alignment and opcode errors are answered with denied responses; no request is ever dropped.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, 2..1024.
- ADDR_BASE, 28'h0800000, byte base address; aligned to DEPTH*4.
- SOURCE_W, 5, width of the source field.

Ports:
- clock  input  1  sole clock.
- reset  input  1  asynchronous, active-low reset.
- auto_in_a_ready  output  1  responder can accept an A beat.
- auto_in_a_valid  input  1  A beat valid.
- auto_in_a_bits_opcode  input  3  0 PutFull, 1 PutPartial, 4 Get; others unsupported.
- auto_in_a_bits_param  input  3  ignored; must be 0.
- auto_in_a_bits_size  input  4  log2 of bytes.
- auto_in_a_bits_source  input  SOURCE_W  request ID.
- auto_in_a_bits_address  input  28  byte address.
- auto_in_a_bits_mask  input  4  byte lanes.
- auto_in_a_bits_data  input  32  write data.
- auto_in_a_bits_corrupt  input  1  write data poisoned.
- auto_in_d_ready  input  1  requester accepts D beat.
- auto_in_d_valid  output  1  D beat valid.
- auto_in_d_bits_opcode  output  3  0 AccessAck, 1 AccessAckData.
- auto_in_d_bits_param  output  2  constant 0.
- auto_in_d_bits_size  output  4  echo of a_size.
- auto_in_d_bits_source  output  SOURCE_W  echo of a_source.
- auto_in_d_bits_sink  output  1  constant 0.
- auto_in_d_bits_denied  output  1  request rejected.
- auto_in_d_bits_data  output  32  read data.
- auto_in_d_bits_corrupt  output  1  data invalid.

Behaviour:
- Reset (reset low, asynchronous): d_valid=0; d_opcode, d_size, d_source, d_denied, d_data, d_corrupt all 0; memory contents are not reset.
- Accept condition: a_fire = a_valid & a_ready.
- Base build: a_ready = !d_valid | d_ready. One D holding register; a request accepted at edge N drives d_valid from N+1.
- Request error = any of:
  - (address - ADDR_BASE) >= DEPTH*4, using 28-bit unsigned compare after subtract;
  - address below ADDR_BASE;
  - size > 2;
  - address not aligned to 2^size;
  - opcode not in {0,1,4}.
- Word index = (address - ADDR_BASE)[log2(DEPTH)+1:2].
- Get:
  - opcode=1;
  - d_data = mem[index] (full word; lanes not masked);
  - on error: denied=1, corrupt=1, data=0.
- PutFull/PutPartial:
  - opcode=0; data=0; corrupt=0;
  - write mem[index] bytes where mask[i]=1, at the a_fire edge;
  - write suppressed if error or a_corrupt=1; denied=1 in both cases.
- Unsupported opcode: respond opcode=0, denied=1, no memory effect.
- Read-after-write: a Get accepted one cycle after a Put to the same word returns the new data.
- Simultaneous d_fire and a_fire in the same cycle: the holding register reloads with the new response and d_valid stays 1.
- D stability: while d_valid & !d_ready, all D outputs hold stable.
- Ordering: responses leave in request order.
- Reset asserted mid-transaction discards any pending response; no response is ever emitted for it.

Optional Feature:
- Macro: TL_RESP_SKID_EN.
- Defined: the D path is a 2-entry FIFO. a_ready = (occupancy < 2), registered with no combinational path from d_ready. Sustains one request per cycle with d_ready toggling. D outputs come from the FIFO head. Reset empties the FIFO.
- Undefined: single holding register as specified above.

Test Plan:
- PutFull addr 0x0800010, mask 0xF, data 0xDEADBEEF, source 3; then Get same address, source 7 -> D: AccessAck (source 3, denied 0), then AccessAckData with data 0xDEADBEEF (source 7), each one cycle after acceptance.
- PutPartial addr 0x0800010, mask 0x2, data 0x00005500; then Get -> data 0xDEAD55EF.
- Get addr 0x0800400 (DEPTH=256) -> opcode 1, denied 1, corrupt 1, data 0. Get addr 0x0800002 with size 2 -> denied 1.
- Put with a_corrupt=1 to 0x0800020, then Get 0x0800020 -> Put denied 1; Get returns the prior contents unchanged.
- Hold d_ready=0 for 5 cycles with a_valid=1 -> a_ready=0 (base build), D outputs stable. Release d_ready -> back-to-back responses in order. With TL_RESP_SKID_EN: exactly 2 requests accepted before a_ready=0.
- Pulse reset low while d_valid=1 -> d_valid=0 immediately (asynchronous), no stale response after reset is released.
